// File: rtl/arith_dispatch.sv
// arith_dispatch: command FIFO plus start/done issue FSM for the multicycle arithmetic unit.
// Optional ARITH_DIV0_GUARD_EN answers divide-by-zero locally instead of issuing it.
module arith_dispatch #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    output logic        alu_start,
    output logic [1:0]  alu_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic [1:0]  rsp_op,
    output logic        rsp_err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(TIMEOUT);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] TO_ONE   = CW'(1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);

    localparam logic [15:0] ERR_RESULT = 16'hFFFF;

    logic [1:0]    state;
    logic [17:0]   mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic [CW-1:0] tcnt;

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [17:0]   head;
    logic [1:0]    head_op;
    logic [7:0]    head_a;
    logic [7:0]    head_b;
    logic          div0;
    logic          timed_out;

    assign full      = (count == CNT_FULL);
    assign empty     = (count == '0);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign pop       = (state == S_IDLE) && !empty;

    assign head = mem[rptr];
    assign {head_op, head_a, head_b} = head;

`ifdef ARITH_DIV0_GUARD_EN
    assign div0 = (head_op == 2'b11) && (head_b == 8'h00);
`else
    assign div0 = 1'b0;
`endif

    assign timed_out = (tcnt == TO_LAST);

    assign alu_start = (state == S_ISSUE);
    assign rsp_valid = (state == S_RESP);
    assign busy      = (state != S_IDLE) || !empty;

    // Command storage; entries are not cleared, occupancy alone says what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= {cmd_op, cmd_a, cmd_b};
        end
    end

    // Read/write pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_ONE;
            end
            if (pop) begin
                rptr <= rptr + PTR_ONE;
            end
        end
    end

    // Occupancy; a same-cycle push and pop leave it unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (push && !pop) begin
            count <= count + CNT_ONE;
        end else if (pop && !push) begin
            count <= count - CNT_ONE;
        end
    end

    // Issue/wait/respond sequencing.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (pop) begin
                        state <= div0 ? S_RESP : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (alu_done || timed_out) begin
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // WAIT-cycle counter, cleared while the start pulse is out.
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt <= '0;
        end else if (state == S_ISSUE) begin
            tcnt <= '0;
        end else if (state == S_WAIT && !alu_done && !timed_out) begin
            tcnt <= tcnt + TO_ONE;
        end
    end

    // Operands to the unit; loaded on pop and held until the next pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_op <= '0;
            alu_a  <= '0;
            alu_b  <= '0;
        end else if (pop) begin
            alu_op <= head_op;
            alu_a  <= head_a;
            alu_b  <= head_b;
        end
    end

    // Response register; written only on entry to RESP so it holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_result <= '0;
            rsp_op     <= '0;
            rsp_err    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (pop && div0) begin
                        rsp_result <= ERR_RESULT;
                        rsp_op     <= head_op;
                        rsp_err    <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (alu_done) begin
                        rsp_result <= alu_result;
                        rsp_op     <= alu_op;
                        rsp_err    <= 1'b0;
                    end else if (timed_out) begin
                        rsp_result <= ERR_RESULT;
                        rsp_op     <= alu_op;
                        rsp_err    <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arith_dispatch.sv
// tb_arith_dispatch: directed bench for arith_dispatch with a small
// behavioural model of the multicycle arithmetic unit.
module tb_arith_dispatch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [7:0]  cmd_a = '0;
    logic [7:0]  cmd_b = '0;
    logic        alu_start;
    logic [1:0]  alu_op;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_done = 1'b0;
    logic [15:0] alu_result = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_result;
    logic [1:0]  rsp_op;
    logic        rsp_err;
    logic        busy;

    int n_checks = 0;
    int n_fail = 0;
    int n_start = 0;

    logic [15:0] log_res[$];
    logic [1:0]  log_op[$];
    logic        log_err[$];

    logic        alu_en = 1'b1;
    int          alu_lat = 1;
    logic        pend = 1'b0;
    int          lc = 0;
    logic [1:0]  m_op = '0;
    logic [7:0]  m_a = '0;
    logic [7:0]  m_b = '0;

    always #5 clk = ~clk;

    arith_dispatch #(.DEPTH(4), .TIMEOUT(64)) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_a(cmd_a),
        .cmd_b(cmd_b),
        .alu_start(alu_start),
        .alu_op(alu_op),
        .alu_a(alu_a),
        .alu_b(alu_b),
        .alu_done(alu_done),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_result(rsp_result),
        .rsp_op(rsp_op),
        .rsp_err(rsp_err),
        .busy(busy)
    );

    function automatic logic [15:0] calc(input logic [1:0] op,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
        case (op)
            2'd0: return {8'h00, a} + {8'h00, b};
            2'd1: return {8'h00, a} - {8'h00, b};
            2'd2: return {8'h00, a} * {8'h00, b};
            default: return (b == 8'h00) ? 16'hDEAD : {8'h00, a} / {8'h00, b};
        endcase
    endfunction

    // Arithmetic unit model: done pulse alu_lat+1 cycles after the start edge.
    always @(posedge clk) begin
        alu_done <= 1'b0;
        if (rst || !alu_en) begin
            pend <= 1'b0;
        end else if (alu_start) begin
            pend <= 1'b1;
            lc   <= alu_lat;
            m_op <= alu_op;
            m_a  <= alu_a;
            m_b  <= alu_b;
        end else if (pend) begin
            if (lc == 0) begin
                alu_done   <= 1'b1;
                alu_result <= calc(m_op, m_a, m_b);
                pend       <= 1'b0;
            end else begin
                lc <= lc - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (alu_start) n_start++;
    end

    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            log_res.push_back(rsp_result);
            log_op.push_back(rsp_op);
            log_err.push_back(rsp_err);
        end
    end

    task automatic push_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        bit ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_wait: cmd_ready stuck low, op=%0d a=%0d b=%0d", op, a, b);
        end else begin
            cmd_valid = 1'b1;
            cmd_op = op;
            cmd_a = a;
            cmd_b = b;
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_rsp(input int n);
        for (int t = 0; t < 400 && log_res.size() < n; t++) begin
            @(negedge clk);
        end
        if (log_res.size() < n) begin
            n_checks++;
            n_fail++;
            $display("FAIL rsp_wait: got %0d responses, need %0d", log_res.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
        end
        n_checks++;
        if (alu_start !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_alu_start: got %b want 0", alu_start);
        end
        n_checks++;
        if ({alu_op, alu_a, alu_b} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_alu_regs: got %h want 0", {alu_op, alu_a, alu_b});
        end
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid);
        end
        n_checks++;
        if ({rsp_result, rsp_op, rsp_err} !== 19'h0) begin
            n_fail++;
            $display("FAIL reset_rsp_regs: got %h want 0", {rsp_result, rsp_op, rsp_err});
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_ops();
        int ops[4] = '{0, 1, 2, 3};
        int av[4] = '{15, 20, 4, 40};
        int bv[4] = '{10, 5, 3, 8};
        int ev[4] = '{25, 15, 12, 5};
        int base;
        int nlog;
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        alu_en = 1'b1;
        alu_lat = 2;
        for (int i = 0; i < 4; i++) begin
            base = n_start;
            nlog = log_res.size();
            push_cmd(2'(ops[i]), 8'(av[i]), 8'(bv[i]));
            wait_rsp(nlog + 1);
            if (log_res.size() > nlog) begin
                n_checks++;
                if (log_res[nlog] !== 16'(ev[i]) || log_err[nlog] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ops_result_%0d: got %0d err %b want %0d err 0",
                             i, log_res[nlog], log_err[nlog], ev[i]);
                end
                n_checks++;
                if (log_op[nlog] !== 2'(ops[i])) begin
                    n_fail++;
                    $display("FAIL ops_op_%0d: got %0d want %0d", i, log_op[nlog], ops[i]);
                end
            end
            n_checks++;
            if (n_start - base != 1) begin
                n_fail++;
                $display("FAIL ops_start_%0d: got %0d pulses want 1", i, n_start - base);
            end
        end
    endtask

    task automatic test_back_to_back();
        int ops[5] = '{0, 1, 2, 3, 0};
        int av[5] = '{1, 9, 7, 100, 200};
        int bv[5] = '{2, 4, 6, 7, 100};
        int ev[5] = '{3, 5, 42, 14, 300};
        int base;
        int nlog;
        bit stuck;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        alu_lat = 1;
        base = n_start;
        nlog = log_res.size();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (cmd_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready_%0d: got %b want 1", i, cmd_ready);
            end
            cmd_valid = 1'b1;
            cmd_op = 2'(ops[i]);
            cmd_a = 8'(av[i]);
            cmd_b = 8'(bv[i]);
        end
        stuck = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            cmd_op = 2'd0;
            cmd_a = 8'd99;
            cmd_b = 8'd99;
            if (cmd_ready !== 1'b0) stuck = 1'b0;
        end
        cmd_valid = 1'b0;
        n_checks++;
        if (!stuck) begin
            n_fail++;
            $display("FAIL b2b_full: cmd_ready got 1 want 0 with 4 queued + 1 in flight");
        end
        repeat (20) @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 16'd3 || log_res.size() != nlog) begin
            n_fail++;
            $display("FAIL b2b_hold: valid %b result %0d logged %0d want 1 3 0",
                     rsp_valid, rsp_result, log_res.size() - nlog);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_rsp(nlog + 5);
        repeat (20) @(negedge clk);
        n_checks++;
        if (log_res.size() != nlog + 5) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d responses want 5", log_res.size() - nlog);
        end
        for (int i = 0; i < 5; i++) begin
            if (log_res.size() > nlog + i) begin
                n_checks++;
                if (log_res[nlog+i] !== 16'(ev[i]) || log_op[nlog+i] !== 2'(ops[i])) begin
                    n_fail++;
                    $display("FAIL b2b_order_%0d: got %0d op %0d want %0d op %0d",
                             i, log_res[nlog+i], log_op[nlog+i], ev[i], ops[i]);
                end
            end
        end
        n_checks++;
        if (n_start - base != 5 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_starts: got %0d pulses busy %b want 5 busy 0",
                     n_start - base, busy);
        end
    endtask

    task automatic test_resp_stall();
        int base;
        int nlog;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        alu_lat = 3;
        base = n_start;
        nlog = log_res.size();
        push_cmd(2'd2, 8'd12, 8'd12);
        push_cmd(2'd0, 8'd1, 8'd1);
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        n_checks++;
        if (rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_reach: rsp_valid got %b want 1", rsp_valid);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_result !== 16'd144 || n_start != base + 1) begin
                n_fail++;
                $display("FAIL stall_%0d: valid %b result %0d starts %0d want 1 144 1",
                         k, rsp_valid, rsp_result, n_start - base);
            end
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_rsp(nlog + 2);
        if (log_res.size() >= nlog + 2) begin
            n_checks++;
            if (log_res[nlog] !== 16'd144 || log_res[nlog+1] !== 16'd2) begin
                n_fail++;
                $display("FAIL stall_results: got %0d,%0d want 144,2",
                         log_res[nlog], log_res[nlog+1]);
            end
        end
        n_checks++;
        if (n_start - base != 2) begin
            n_fail++;
            $display("FAIL stall_starts: got %0d want 2", n_start - base);
        end
    endtask

    task automatic test_timeout();
        int nlog;
        bit seen = 1'b0;
        bit early = 1'b0;
        @(posedge clk);
        #1;
        alu_en = 1'b0;
        rsp_ready = 1'b0;
        nlog = log_res.size();
        push_cmd(2'd1, 8'd50, 8'd8);
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (alu_start) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL timeout_start: no alu_start pulse seen");
        end
        @(posedge clk);
        for (int j = 1; j <= 64; j++) begin
            @(negedge clk);
            if (rsp_valid) early = 1'b1;
        end
        n_checks++;
        if (early) begin
            n_fail++;
            $display("FAIL timeout_early: rsp_valid got 1 within 64 cycles of WAIT entry");
        end
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 16'hFFFF || rsp_err !== 1'b1 || rsp_op !== 2'd1) begin
            n_fail++;
            $display("FAIL timeout_rsp: valid %b result %h err %b op %0d want 1 ffff 1 1",
                     rsp_valid, rsp_result, rsp_err, rsp_op);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        alu_en = 1'b1;
        alu_lat = 1;
        wait_rsp(nlog + 1);
        push_cmd(2'd0, 8'd7, 8'd8);
        wait_rsp(nlog + 2);
        if (log_res.size() >= nlog + 2) begin
            n_checks++;
            if (log_res[nlog+1] !== 16'd15 || log_err[nlog+1] !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_next: got %0d err %b want 15 err 0",
                         log_res[nlog+1], log_err[nlog+1]);
            end
        end
    endtask

    task automatic test_div0();
        int base;
        int nlog;
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        alu_en = 1'b1;
        base = n_start;
        nlog = log_res.size();
        push_cmd(2'd3, 8'd40, 8'd0);
        wait_rsp(nlog + 1);
`ifdef ARITH_DIV0_GUARD_EN
        if (log_res.size() > nlog) begin
            n_checks++;
            if (log_res[nlog] !== 16'hFFFF || log_err[nlog] !== 1'b1 || log_op[nlog] !== 2'd3) begin
                n_fail++;
                $display("FAIL div0_rsp: got %h err %b op %0d want ffff 1 3",
                         log_res[nlog], log_err[nlog], log_op[nlog]);
            end
        end
        n_checks++;
        if (n_start != base) begin
            n_fail++;
            $display("FAIL div0_start: got %0d pulses want 0", n_start - base);
        end
`else
        if (log_res.size() > nlog) begin
            n_checks++;
            if (log_res[nlog] !== 16'hDEAD || log_err[nlog] !== 1'b0 || log_op[nlog] !== 2'd3) begin
                n_fail++;
                $display("FAIL div0_rsp: got %h err %b op %0d want dead 0 3",
                         log_res[nlog], log_err[nlog], log_op[nlog]);
            end
        end
        n_checks++;
        if (n_start - base != 1) begin
            n_fail++;
            $display("FAIL div0_start: got %0d pulses want 1", n_start - base);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int base;
        int nlog;
        bit quiet = 1'b1;
        @(posedge clk);
        #1;
        alu_en = 1'b0;
        rsp_ready = 1'b1;
        base = n_start;
        nlog = log_res.size();
        push_cmd(2'd0, 8'd1, 8'd1);
        push_cmd(2'd1, 8'd2, 8'd2);
        push_cmd(2'd2, 8'd3, 8'd3);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        alu_en = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({cmd_ready, alu_start, rsp_valid, busy} !== 4'b1000) begin
            n_fail++;
            $display("FAIL midrst_ctrl: ready/start/valid/busy got %b want 1000",
                     {cmd_ready, alu_start, rsp_valid, busy});
        end
        n_checks++;
        if ({alu_op, alu_a, alu_b, rsp_result, rsp_op, rsp_err} !== 37'h0) begin
            n_fail++;
            $display("FAIL midrst_regs: got %h want 0",
                     {alu_op, alu_a, alu_b, rsp_result, rsp_op, rsp_err});
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid || busy) quiet = 1'b0;
        end
        n_checks++;
        if (!quiet || log_res.size() != nlog || n_start - base != 1) begin
            n_fail++;
            $display("FAIL midrst_drop: quiet %b responses %0d starts %0d want 1 0 1",
                     quiet, log_res.size() - nlog, n_start - base);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ops();
        test_back_to_back();
        test_resp_stall();
        test_timeout();
        test_div0();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
